priority_shiphrator_stream: RTL and testbench



---
 rtl/priority_shiphrator_stream_pkg.sv | 15 +
 rtl/onehot_decoder.sv | 23 ++
 rtl/priority_shiphrator_stream.sv | 88 ++++++++
 tb/tb_priority_shiphrator_stream.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/priority_shiphrator_stream_pkg.sv
// Shared widths and FSM encoding for the index-to-bit-vector stream assembler.
// The default widths match the priority decoder, so both ends of the round trip agree.
package priority_shiphrator_stream_pkg;

  localparam int unsigned DefIdxW = 3;
  localparam int unsigned DefOutW = 8;
  localparam int unsigned DefCntW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StOut
  } state_e;

endpackage

// File: rtl/onehot_decoder.sv
// Maps a bit index to a one-hot OUT_W word.
// The word is all zeros and oor_o is raised when the index has no bit in the word.
module onehot_decoder #(
  parameter int unsigned IDX_W = 3,
  parameter int unsigned OUT_W = 8
) (
  input  logic [IDX_W-1:0] num_i,
  output logic [OUT_W-1:0] onehot_o,
  output logic             oor_o
);

  always_comb begin
    onehot_o = '0;
    oor_o    = 1'b1;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      if (num_i == IDX_W'(i)) begin
        onehot_o[i] = 1'b1;
        oor_o       = 1'b0;
      end
    end
  end

endmodule

// File: rtl/priority_shiphrator_stream.sv
// Accumulates a stream of bit indices into a mask.
// The beat flagged last emits the mask as a registered word with a saturating beat count.
module priority_shiphrator_stream
  import priority_shiphrator_stream_pkg::*;
#(
  parameter int unsigned IDX_W = DefIdxW,
  parameter int unsigned OUT_W = DefOutW,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] num,
  input  logic             in_last,
  output logic             ub_valid,
  input  logic             ub_ready,
  output logic [OUT_W-1:0] ub,
  output logic [CNT_W-1:0] ub_cnt,
  output logic             err
);

  state_e             state_q;
  logic [OUT_W-1:0]   mask_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [OUT_W-1:0]   ub_q;
  logic [CNT_W-1:0]   ub_cnt_q;
  logic               ub_valid_q;
  logic               err_q;

  logic [OUT_W-1:0]   onehot;
  logic               oor;
  logic               beat_acc;
  logic [CNT_W-1:0]   cnt_inc;

  onehot_decoder #(
    .IDX_W (IDX_W),
    .OUT_W (OUT_W)
  ) u_onehot_decoder (
    .num_i    (num),
    .onehot_o (onehot),
    .oor_o    (oor)
  );

  assign in_ready = !ub_valid_q || ub_ready;
  assign beat_acc = in_valid && in_ready;
  assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      cnt_q      <= '0;
      ub_q       <= '0;
      ub_cnt_q   <= '0;
      ub_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= beat_acc && oor;
      if (ub_valid_q && ub_ready) begin
        ub_valid_q <= 1'b0;
      end
      if (beat_acc) begin
        if (in_last) begin
          // A last beat overrides the transfer-clear above: the new word replaces the old.
          ub_q       <= mask_q | onehot;
          ub_cnt_q   <= cnt_inc;
          ub_valid_q <= 1'b1;
          mask_q     <= '0;
          cnt_q      <= '0;
          state_q    <= StOut;
        end else begin
          mask_q  <= mask_q | onehot;
          cnt_q   <= cnt_inc;
          state_q <= StAcc;
        end
      end else if (state_q == StOut && ub_ready) begin
        state_q <= (mask_q != '0) ? StAcc : StIdle;
      end
    end
  end

  assign ub_valid = ub_valid_q;
  assign ub       = ub_q;
  assign ub_cnt   = ub_cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_priority_shiphrator_stream.sv
// Randomized and directed bench for the index-to-word assembler, checked against a word-level model.
module tb_priority_shiphrator_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_last, ub_ready;
  logic [2:0] num;
  logic       in_ready, ub_valid, err;
  logic [7:0] ub;
  logic [3:0] ub_cnt;

  logic       d4_valid, d4_last, d4_ready;
  logic [2:0] d4_num;
  logic       d4_in_ready, d4_ub_valid, d4_err;
  logic [3:0] d4_ub;
  logic [3:0] d4_ub_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Model: indices of the open word plus the expected registered outputs.
  int         m_idx[$];
  bit         m_valid;
  logic [7:0] m_ub;
  int         m_cnt;
  bit         m_err;
  int         m_hi;
  bit         m_new;

  always #5 clk = ~clk;

  priority_shiphrator_stream dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .num      (num),
    .in_last  (in_last),
    .ub_valid (ub_valid),
    .ub_ready (ub_ready),
    .ub       (ub),
    .ub_cnt   (ub_cnt),
    .err      (err)
  );

  priority_shiphrator_stream #(
    .IDX_W (3),
    .OUT_W (4),
    .CNT_W (4)
  ) dut4 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (d4_valid),
    .in_ready (d4_in_ready),
    .num      (d4_num),
    .in_last  (d4_last),
    .ub_valid (d4_ub_valid),
    .ub_ready (d4_ready),
    .ub       (d4_ub),
    .ub_cnt   (d4_ub_cnt),
    .err      (d4_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int highest_bit(input logic [7:0] w);
    int hi = -1;
    for (int i = 0; i < 8; i++) if (w[i]) hi = i;
    return hi;
  endfunction

  task automatic model_reset();
    m_idx.delete();
    m_valid = 0;
    m_ub    = '0;
    m_cnt   = 0;
    m_err   = 0;
    m_new   = 0;
  endtask

  // One clock: drive a beat, check in_ready, advance the model, check registered outputs.
  task automatic cycle(input bit v, input int n, input bit l, input bit r);
    bit acc;
    in_valid = v;
    num      = n[2:0];
    in_last  = l;
    ub_ready = r;
    #1;
    check("in_ready", 32'(in_ready), 32'(!m_valid || r));
    acc = v && (!m_valid || r);
    @(posedge clk);
    m_err = acc && (n >= 8);
    m_new = 0;
    if (m_valid && r) m_valid = 0;
    if (acc) begin
      m_idx.push_back(n);
      if (l) begin
        m_ub = '0;
        m_hi = -1;
        foreach (m_idx[k]) begin
          if (m_idx[k] < 8) begin
            m_ub[m_idx[k]] = 1'b1;
            if (m_idx[k] > m_hi) m_hi = m_idx[k];
          end
        end
        m_cnt   = (m_idx.size() > 15) ? 15 : m_idx.size();
        m_valid = 1;
        m_new   = 1;
        m_idx.delete();
      end
    end
    #1;
    check("ub_valid", 32'(ub_valid), 32'(m_valid));
    check("err", 32'(err), 32'(m_err));
    if (m_valid) begin
      check("ub", 32'(ub), 32'(m_ub));
      check("ub_cnt", 32'(ub_cnt), 32'(m_cnt));
      if (m_new && m_ub != 0) check("prio_roundtrip", 32'(highest_bit(ub)), 32'(m_hi));
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; in_last = 0; ub_ready = 0; num = '0;
    d4_valid = 0; d4_last = 0; d4_ready = 1; d4_num = '0;
    model_reset();
    #12;
    check("rst_ub_valid", 32'(ub_valid), 32'd0);
    check("rst_ub", 32'(ub), 32'd0);
    check("rst_ub_cnt", 32'(ub_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Back-to-back single-beat words.
    cycle(1, 6, 1, 1); check("onehot6", 32'(ub), 32'h40);
    cycle(1, 3, 1, 1); check("onehot3", 32'(ub), 32'h08);
    cycle(1, 0, 1, 1); check("onehot0", 32'(ub), 32'h01);
    check("onehot_cnt", 32'(ub_cnt), 32'd1);

    cycle(1, 2, 0, 1);
    cycle(1, 3, 0, 1);
    cycle(1, 6, 1, 1); check("word236", 32'(ub), 32'h4c);
    check("word236_cnt", 32'(ub_cnt), 32'd3);

    // Hold under backpressure, then release together with a new last beat.
    for (int i = 0; i < 5; i++) cycle(1, 5, 1, 0);
    check("hold_ub", 32'(ub), 32'h4c);
    cycle(1, 1, 1, 1); check("nobubble", 32'(ub), 32'h02);

    cycle(1, 0, 0, 1);
    cycle(1, 1, 0, 1);
    cycle(1, 0, 0, 1);
    cycle(1, 3, 1, 1); check("dup_word", 32'(ub), 32'h0b);
    check("dup_cnt", 32'(ub_cnt), 32'd4);

    for (int i = 0; i < 20; i++) cycle(1, int'($urandom_range(0, 7)), 0, 1);
    cycle(1, 7, 1, 1); check("sat_cnt", 32'(ub_cnt), 32'd15);

    // Async reset with a held word.
    cycle(1, 4, 1, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(ub_valid), 32'd0);
    check("arst_ub", 32'(ub), 32'd0);
    model_reset();
    rst = 1'b0;
    @(posedge clk); #1;

    // Async reset mid-word must discard the partial mask.
    cycle(1, 4, 0, 1);
    cycle(1, 7, 0, 1);
    #2 rst = 1'b1;
    #1;
    check("arst2_valid", 32'(ub_valid), 32'd0);
    check("arst2_ub", 32'(ub), 32'd0);
    model_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    cycle(1, 1, 1, 1); check("post_rst_word", 32'(ub), 32'h02);

    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
            bit'($urandom_range(0, 2) == 0), bit'($urandom_range(0, 3) != 0));
    end

    // Narrow instance: index 5 has no bit in a 4-bit word.
    @(posedge clk); #1;
    d4_valid = 1; d4_num = 3'd5; d4_last = 1; d4_ready = 1;
    @(posedge clk); #1;
    d4_valid = 0;
    check("oor_valid", 32'(d4_ub_valid), 32'd1);
    check("oor_ub", 32'(d4_ub), 32'd0);
    check("oor_cnt", 32'(d4_ub_cnt), 32'd1);
    check("oor_err", 32'(d4_err), 32'd1);
    @(posedge clk); #1;
    check("oor_err_clr", 32'(d4_err), 32'd0);
    check("oor_valid_clr", 32'(d4_ub_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
